sub_lectura_filtrada: RTL and testbench

Multi-channel input capture stage for the Booth datapath. Each channel passes an asynchronous `ancho`-bit operand through a configurable-depth flip-flop synchroniser, then a stability filter. The filter accepts a new value only after it has been held for `estable` consecutive cycles, and flags each accepted change with a one-cycle `valido` pulse. A runtime bypass mode drops the filter and forwards every synchronised change.

---
 rtl/lectura_pkg.sv | 16 +
 rtl/lectura_canal.sv | 65 ++++++
 rtl/sub_lectura_filtrada.sv | 41 ++++
 tb/tb_sub_lectura_filtrada.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/lectura_pkg.sv
// Shared constants and helpers for the Booth-level input capture stage.
package lectura_pkg;

  localparam int ANCHO_DEF   = 4;
  localparam int CANALES_DEF = 2;
  localparam int ETAPAS_DEF  = 2;
  localparam int ESTABLE_DEF = 4;

  // Stability counter width; never narrower than one bit.
  function automatic int cnt_ancho(input int estable);
    int w;
    w = $clog2(estable);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lectura_canal.sv
// One capture channel: flip-flop synchroniser, stability counter and
// registered output with a one-cycle change pulse.
module lectura_canal
  import lectura_pkg::*;
#(
  parameter int ancho   = ANCHO_DEF,
  parameter int etapas  = ETAPAS_DEF,
  parameter int estable = ESTABLE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             filtro_en,
  input  logic [ancho-1:0] in_c,
  output logic [ancho-1:0] out_c,
  output logic             valido_c
);

  localparam int            CW      = cnt_ancho(estable);
  localparam logic [CW-1:0] CNT_MAX = CW'(estable - 1);

  logic [etapas-1:0][ancho-1:0] s;
  logic [ancho-1:0]             sinc;
  logic [ancho-1:0]             cand;
  logic [CW-1:0]                cnt;
  logic                         cambio;
  logic                         aceptar;
  logic [ancho-1:0]             out_nxt;

  assign sinc   = s[etapas-1];
  assign cambio = (sinc != cand);

  // Filter mode accepts the candidate only once it has been seen stable for
  // the full window; a change on the saturating edge wins over acceptance.
  always_comb begin
    aceptar = 1'b0;
    out_nxt = out_c;
    if (filtro_en) begin
      aceptar = (cnt == CNT_MAX) && !cambio && (cand != out_c);
      out_nxt = cand;
    end else begin
      aceptar = (sinc != out_c);
      out_nxt = sinc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s        <= '0;
      cand     <= '0;
      cnt      <= '0;
      out_c    <= '0;
      valido_c <= 1'b0;
    end else begin
      s    <= {s[etapas-2:0], in_c};
      cand <= sinc;
      // cand and cnt keep tracking in bypass so a later switch to filter
      // mode can accept an already-stable value immediately.
      if (cambio)             cnt <= '0;
      else if (cnt < CNT_MAX) cnt <= cnt + 1'b1;
      valido_c <= aceptar;
      if (aceptar) out_c <= out_nxt;
    end
  end

endmodule

// File: rtl/sub_lectura_filtrada.sv
// Multi-channel synchronise-and-filter capture stage; one lectura_canal
// per channel, fields packed channel 0 in the low bits.
module sub_lectura_filtrada
  import lectura_pkg::*;
#(
  parameter int ancho   = ANCHO_DEF,
  parameter int canales = CANALES_DEF,
  parameter int etapas  = ETAPAS_DEF,
  parameter int estable = ESTABLE_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [canales*ancho-1:0] in,
  input  logic                     filtro_en,
  output logic [canales*ancho-1:0] out,
  output logic [canales-1:0]       valido
);

  if (etapas < 2) begin : g_chk_etapas
    $error("sub_lectura_filtrada: etapas must be >= 2");
  end
  if (estable < 2) begin : g_chk_estable
    $error("sub_lectura_filtrada: estable must be >= 2");
  end

  for (genvar c = 0; c < canales; c++) begin : g_canal
    lectura_canal #(
      .ancho  (ancho),
      .etapas (etapas),
      .estable(estable)
    ) u_canal (
      .clk      (clk),
      .rst      (rst),
      .filtro_en(filtro_en),
      .in_c     (in[c*ancho +: ancho]),
      .out_c    (out[c*ancho +: ancho]),
      .valido_c (valido[c])
    );
  end

endmodule

// File: tb/tb_sub_lectura_filtrada.sv
// Directed plus randomized bench for sub_lectura_filtrada against a
// window-based reference model of the synchronised sample history.
module tb_sub_lectura_filtrada;

  localparam int A = 4;
  localparam int C = 2;
  localparam int E = 2;
  localparam int S = 4;
  localparam int N = 4096;

  logic             clk = 1'b0;
  logic             rst;
  logic             filtro_en;
  logic [C*A-1:0]   in;
  logic [C*A-1:0]   out;
  logic [C-1:0]     valido;

  always #5 clk = ~clk;

  sub_lectura_filtrada #(.ancho(A), .canales(C), .etapas(E), .estable(S)) dut (
    .clk(clk), .rst(rst), .in(in), .filtro_en(filtro_en), .out(out), .valido(valido)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;
  int last_rst = 0;

  // sh: synchronised value after each edge; ih: raw input sampled at each edge
  logic [A-1:0] sh [C][N];
  logic [A-1:0] ih [C][N];
  logic [A-1:0] om [C];
  logic         vm [C];

  int v0_cnt, v0_last, v1_cnt, vb_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s edge %0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  // Samples before the last reset read as zero (the cleared candidate).
  function automatic logic [A-1:0] sget(input int c, input int j);
    if (j < last_rst) return '0;
    return sh[c][j];
  endfunction

  task automatic step(input logic r, input logic f, input logic [C*A-1:0] v);
    logic [A-1:0]   cur;
    logic           acc;
    logic [C*A-1:0] oexp;
    logic [C-1:0]   vexp;
    rst = r; filtro_en = f; in = v;
    @(posedge clk);
    for (int c = 0; c < C; c++) begin
      if (r) begin
        om[c] = '0; vm[c] = 1'b0; sh[c][k] = '0;
      end else begin
        cur = sget(c, k-1);
        if (f) begin
          // stable for S+1 consecutive synchronised samples, and new
          acc = (k-S-1 >= last_rst-1) && (cur != om[c]);
          for (int j = k-S-1; j < k-1; j++)
            if (sget(c, j) != cur) acc = 1'b0;
        end else begin
          acc = (cur != om[c]);
        end
        vm[c] = acc;
        if (acc) om[c] = cur;
        sh[c][k] = (k-E+1 > last_rst) ? ih[c][k-E+1] : '0;
      end
      ih[c][k] = v[c*A +: A];
    end
    if (r) last_rst = k;
    #1;
    for (int c = 0; c < C; c++) begin
      oexp[c*A +: A] = om[c];
      vexp[c]        = vm[c];
    end
    chk("out", 32'(out), 32'(oexp));
    chk("valido", 32'(valido), 32'(vexp));
    if (valido[0] === 1'b1) begin v0_cnt++; v0_last = k; end
    if (valido[1] === 1'b1) v1_cnt++;
    if (valido === 2'b11) vb_last = k;
    k++;
  endtask

  initial begin
    int k0;
    logic [C*A-1:0] rv;
    logic rr, rf;
    rf = 1'b1;

    // reset with inputs high, then zero input: no pulse
    repeat (3) step(1'b1, 1'b1, 8'hFF);
    v0_cnt = 0; v1_cnt = 0;
    repeat (4) step(1'b0, 1'b1, 8'h00);
    chk("rst_no_pulse", 32'(v0_cnt + v1_cnt), 32'd0);

    // filter latency on ch0
    k0 = k; v0_cnt = 0; v1_cnt = 0; v0_last = -1;
    repeat (10) step(1'b0, 1'b1, 8'h0A);
    chk("filt_lat", 32'(v0_last - k0), 32'd6);
    chk("filt_pulses", 32'(v0_cnt), 32'd1);
    chk("filt_ch1_quiet", 32'(v1_cnt), 32'd0);

    // glitch on ch1 shorter than the window
    v1_cnt = 0;
    repeat (3) step(1'b0, 1'b1, 8'h5A);
    repeat (8) step(1'b0, 1'b1, 8'h0A);
    chk("glitch_pulses", 32'(v1_cnt), 32'd0);
    chk("glitch_out", 32'(out[7:4]), 32'd0);

    // both channels change together
    k0 = k; vb_last = -1;
    repeat (8) step(1'b0, 1'b1, 8'hC3);
    chk("simul_lat", 32'(vb_last - k0), 32'd6);

    // bypass: 1 for a cycle, then 2
    k0 = k; v0_cnt = 0; v0_last = -1;
    step(1'b0, 1'b0, 8'hC1);
    repeat (4) step(1'b0, 1'b0, 8'hC2);
    chk("byp_pulses", 32'(v0_cnt), 32'd2);
    chk("byp_last", 32'(v0_last - k0), 32'd3);

    // reset in the middle of a pending acceptance
    k0 = k;
    repeat (4) step(1'b0, 1'b1, 8'h09);
    step(1'b1, 1'b1, 8'h09);
    chk("midrst_out", 32'(out), 32'd0);
    k0 = k; v0_cnt = 0; v0_last = -1;
    repeat (9) step(1'b0, 1'b1, 8'h09);
    chk("midrst_lat", 32'(v0_last - k0), 32'd6);
    chk("midrst_pulses", 32'(v0_cnt), 32'd1);

    // random: sparse resets, occasional mode flips, glitchy inputs
    rv = 8'h09;
    for (int i = 0; i < 2000; i++) begin
      rr = ($urandom_range(49) == 0);
      if ($urandom_range(29) == 0) rf = ~rf;
      for (int c = 0; c < C; c++)
        if ($urandom_range(3) == 0) rv[c*A +: A] = 4'($urandom_range(3));
      step(rr, rf, rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
